// File: rtl/cdc_bus_arbiter.sv
`timescale 1ns/1ps
// cdc_bus_arbiter: round-robin arbiter that feeds one word at a time into a
// clock-domain-crossing bus. It uses a strobe/busy handshake and counts the
// completed transfers. An acknowledge that takes too long sets a sticky error.
module cdc_bus_arbiter #(
    parameter int size    = 7,
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clkA,
    input  logic                  rstA_n,
    input  logic [N-1:0]          req,
    input  logic [N*(size+1)-1:0] data_in,
    output logic [N-1:0]          gnt,
    input  logic                  Busy_clkA,
    output logic                  FlagIn_clkA,
    output logic [size:0]         BusIn,
    output logic [2:0]            gnt_id,
    output logic [15:0]           xfer_cnt,
    output logic                  err_timeout
);
    localparam int W = size + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t       state, stateNext;
    logic [15:0]  waitCnt;
    logic [7:0]   reqExt;
    logic [W-1:0] words [8];
    logic [2:0]   winIdx, cand;
    logic         winFound, start, ackSeen, atLimit;

    // Widen requests and words to 8 slots so a 3-bit index is always in range
    always_comb begin
        reqExt        = '0;
        reqExt[N-1:0] = req;
        for (int k = 0; k < 8; k++) words[k] = '0;
        for (int k = 0; k < N; k++) words[k] = data_in[k*W +: W];
    end

    // Round-robin search: begin at the slot after the last grant and wrap
    always_comb begin
        winIdx   = gnt_id;
        winFound = 1'b0;
        cand     = '0;
        for (int i = 1; i <= N; i++) begin
            cand = 3'((int'(gnt_id) + i) % N);
            if (!winFound && reqExt[cand]) begin
                winIdx   = cand;
                winFound = 1'b1;
            end
        end
    end

    // Handshake qualifiers. Busy is ignored on the first WAIT_ACK cycle
    // because the crossing raises it one cycle after the strobe.
    always_comb begin
        start   = (state == IDLE) && winFound && !Busy_clkA;
        ackSeen = (state == WAIT_ACK) && (waitCnt != 16'd0) && !Busy_clkA;
        atLimit = (waitCnt == 16'(TIMEOUT));
    end

    // FSM next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (start) stateNext = ISSUE;
            ISSUE:    stateNext = WAIT_ACK;
            WAIT_ACK: if (ackSeen) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clkA) begin
        if (!rstA_n) state <= IDLE;
        else         state <= stateNext;
    end

    // Registered outputs: strobe/grant pulse, latched word, counters, sticky error
    always_ff @(posedge clkA) begin
        if (!rstA_n) begin
            FlagIn_clkA <= 1'b0;
            gnt         <= '0;
            BusIn       <= '0;
            gnt_id      <= 3'(N - 1);
            xfer_cnt    <= '0;
            err_timeout <= 1'b0;
            waitCnt     <= '0;
        end else begin
            FlagIn_clkA <= 1'b0;
            gnt         <= '0;
            xfer_cnt    <= xfer_cnt + {15'd0, ackSeen};
            if (start) begin
                FlagIn_clkA <= 1'b1;
                gnt         <= N'(1) << winIdx;
                BusIn       <= words[winIdx];
                gnt_id      <= winIdx;
            end
            if (state == ISSUE) begin
                waitCnt <= '0;
            end else if (state == WAIT_ACK && !ackSeen) begin
                // Saturate at the limit; Busy still high there means a timeout
                if (atLimit) begin
                    if (Busy_clkA) err_timeout <= 1'b1;
                end else begin
                    waitCnt <= waitCnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdc_bus_arbiter.sv
`timescale 1ns/1ps
// tb_cdc_bus_arbiter: vector table, directed corner sequences, then random
// traffic compared against a transaction-level reference model.
module tb_cdc_bus_arbiter;
    localparam int N  = 4;
    localparam int SZ = 7;
    localparam int TO = 4;

    logic                clkA = 1'b0;
    logic                rstA_n;
    logic [N-1:0]        req;
    logic [N*(SZ+1)-1:0] data_in;
    logic [N-1:0]        gnt;
    logic                Busy_clkA;
    logic                FlagIn_clkA;
    logic [SZ:0]         BusIn;
    logic [2:0]          gnt_id;
    logic [15:0]         xfer_cnt;
    logic                err_timeout;

    int passCnt  = 0;
    int checkCnt = 0;

    cdc_bus_arbiter #(.size(SZ), .N(N), .TIMEOUT(TO)) dut (
        .clkA(clkA), .rstA_n(rstA_n), .req(req), .data_in(data_in), .gnt(gnt),
        .Busy_clkA(Busy_clkA), .FlagIn_clkA(FlagIn_clkA), .BusIn(BusIn),
        .gnt_id(gnt_id), .xfer_cnt(xfer_cnt), .err_timeout(err_timeout)
    );

    always #5 clkA = ~clkA;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clkA);
        @(negedge clkA);
    endtask

    task automatic doReset();
        rstA_n = 1'b0; req = '0; Busy_clkA = 1'b0; data_in = '0;
        tick();
        rstA_n = 1'b1;
    endtask

    function automatic int ohIdx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (((v >> i) & N'(1)) != '0) r = i;
        return r;
    endfunction

    function automatic logic [63:0] actVec();
        return 64'({FlagIn_clkA, gnt, BusIn, gnt_id, xfer_cnt, err_timeout});
    endfunction

    // ---- reference model: transfer phase = cycles since the strobe ----
    int          mPhase;  // -1: no transfer outstanding, 0: strobe cycle, k: k-th cycle after
    logic        mFlag, mErr;
    logic [N-1:0] mGnt;
    logic [7:0]  mBus;
    logic [2:0]  mId;
    logic [15:0] mXfer;

    task automatic modelStep(input logic r, input logic [N-1:0] rq, input logic b,
                             input logic [31:0] d);
        bit found;
        int idx;
        mFlag = 1'b0; mGnt = '0;
        if (!r) begin
            mPhase = -1; mId = 3'(N - 1); mBus = '0; mXfer = '0; mErr = 1'b0;
        end else if (mPhase < 0) begin
            if (rq != '0 && !b) begin
                found = 0;
                for (int i = 1; i <= N; i++) begin
                    idx = (int'(mId) + i) % N;
                    if (!found && ((rq >> idx) & N'(1)) != '0) begin
                        found = 1;
                        mFlag = 1'b1;
                        mGnt  = N'(1) << idx;
                        mBus  = 8'(d >> (idx * 8));
                        mId   = 3'(idx);
                    end
                end
                mPhase = 0;
            end
        end else if (mPhase == 0) begin
            mPhase = 1;
        end else if (mPhase >= 2 && !b) begin
            mXfer  = mXfer + 16'd1;
            mPhase = -1;
        end else begin
            if (b && (mPhase - 1) >= TO) mErr = 1'b1;
            mPhase = mPhase + 1;
        end
    endtask

    typedef struct packed {
        logic        rst_n;
        logic [N-1:0] rq;
        logic        busy;
        logic [31:0] data;
        logic        flag;
        logic [N-1:0] g;
        logic [7:0]  bus;
        logic [2:0]  id;
        logic [15:0] xfer;
        logic        err;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int order[$];
        int seen, lastFlag, cyc;
        logic [N-1:0] reqHeld;

        rstA_n = 1'b0; req = '0; Busy_clkA = 1'b0; data_in = '0;
        @(negedge clkA);

        // ---- vector table: {rst_n, req, busy, data, flag, gnt, BusIn, gnt_id, xfer, err}
        tbl[0]  = '{1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 4'b0000, 8'h00, 3'd3, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0100, 1'b0, 32'h00A50000, 1'b1, 4'b0100, 8'hA5, 3'd2, 16'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'b0000, 1'b1, 32'h0,        1'b0, 4'b0000, 8'hA5, 3'd2, 16'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'b0000, 1'b1, 32'h0,        1'b0, 4'b0000, 8'hA5, 3'd2, 16'd0, 1'b0};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 32'h0,        1'b0, 4'b0000, 8'hA5, 3'd2, 16'd1, 1'b0};
        tbl[5]  = '{1'b1, 4'b0001, 1'b1, 32'h0000003C, 1'b0, 4'b0000, 8'hA5, 3'd2, 16'd1, 1'b0};
        tbl[6]  = '{1'b1, 4'b0001, 1'b0, 32'h0000003C, 1'b1, 4'b0001, 8'h3C, 3'd0, 16'd1, 1'b0};
        tbl[7]  = '{1'b1, 4'b0000, 1'b0, 32'h0,        1'b0, 4'b0000, 8'h3C, 3'd0, 16'd1, 1'b0};
        tbl[8]  = '{1'b1, 4'b0000, 1'b0, 32'h0,        1'b0, 4'b0000, 8'h3C, 3'd0, 16'd1, 1'b0};
        tbl[9]  = '{1'b1, 4'b0000, 1'b0, 32'h0,        1'b0, 4'b0000, 8'h3C, 3'd0, 16'd2, 1'b0};
        tbl[10] = '{1'b1, 4'b1010, 1'b0, 32'h11223344, 1'b1, 4'b0010, 8'h33, 3'd1, 16'd2, 1'b0};
        tbl[11] = '{1'b1, 4'b1000, 1'b0, 32'h11223344, 1'b0, 4'b0000, 8'h33, 3'd1, 16'd2, 1'b0};
        tbl[12] = '{1'b1, 4'b1000, 1'b0, 32'h11223344, 1'b0, 4'b0000, 8'h33, 3'd1, 16'd2, 1'b0};
        tbl[13] = '{1'b1, 4'b1000, 1'b0, 32'h11223344, 1'b0, 4'b0000, 8'h33, 3'd1, 16'd3, 1'b0};
        tbl[14] = '{1'b1, 4'b1000, 1'b0, 32'hEE000000, 1'b1, 4'b1000, 8'hEE, 3'd3, 16'd3, 1'b0};
        for (int i = 0; i < 15; i++) begin
            rstA_n = tbl[i].rst_n; req = tbl[i].rq; Busy_clkA = tbl[i].busy; data_in = tbl[i].data;
            tick();
            check($sformatf("tbl%0d", i), actVec(),
                  64'({tbl[i].flag, tbl[i].g, tbl[i].bus, tbl[i].id, tbl[i].xfer, tbl[i].err}));
        end

        // ---- round robin with all requests held, Busy always ready ----
        doReset();
        req = 4'b1111; data_in = 32'h44332211; Busy_clkA = 1'b0;
        lastFlag = -100; cyc = 0;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            tick(); cyc++;
            if (FlagIn_clkA) begin
                check("rr_spacing", 64'(cyc - lastFlag >= 3), 64'(1));
                lastFlag = cyc;
                check("rr_flag_gnt", 64'(gnt != '0), 64'(1));
            end
            if (gnt != '0) begin
                order.push_back(ohIdx(gnt));
                check("rr_bus", 64'(BusIn), 64'(8'h11 * (ohIdx(gnt) + 1)));
            end
        end
        req = '0;
        check("rr_count", 64'(order.size()), 64'(5));
        for (int i = 0; i < order.size(); i++) check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i % N));
        repeat (6) tick();
        check("rr_xfer", 64'(xfer_cnt), 64'(5));

        // ---- Busy hold-off ----
        doReset();
        Busy_clkA = 1'b1; req = 4'b0001; data_in = 32'h5A; seen = 0;
        repeat (10) begin tick(); if (FlagIn_clkA) seen++; end
        check("holdoff_noflag", 64'(seen), 64'(0));
        Busy_clkA = 1'b0;
        tick();
        check("holdoff_flag", 64'({FlagIn_clkA, gnt, BusIn}), 64'({1'b1, 4'b0001, 8'h5A}));

        // ---- timeout: TIMEOUT=4, error appears at the end of WAIT_ACK cycle 5 ----
        doReset();
        req = 4'b0001; Busy_clkA = 1'b0;
        tick();
        check("to_flag", 64'(FlagIn_clkA), 64'(1));
        req = '0; Busy_clkA = 1'b1;
        repeat (5) tick();
        check("to_err_before", 64'(err_timeout), 64'(0));
        tick();
        check("to_err_set", 64'(err_timeout), 64'(1));
        Busy_clkA = 1'b0;
        tick();
        check("to_xfer", 64'(xfer_cnt), 64'(1));
        repeat (3) tick();
        check("to_err_sticky", 64'(err_timeout), 64'(1));

        // ---- reset in the middle of a transfer ----
        doReset();
        req = 4'b0010; data_in = 32'h0000C300; Busy_clkA = 1'b0;
        tick(); req = '0;
        repeat (3) tick();
        check("rst_prexfer", 64'(xfer_cnt), 64'(1));
        req = 4'b0100; data_in = 32'h00770000;
        tick(); req = '0; Busy_clkA = 1'b1;
        repeat (2) tick();
        rstA_n = 1'b0;
        tick();
        check("rst_mid", actVec(), 64'({1'b0, 4'b0000, 8'h00, 3'd3, 16'd0, 1'b0}));
        rstA_n = 1'b1; req = 4'b0001; seen = 0;
        repeat (3) begin tick(); if (FlagIn_clkA) seen++; end
        check("rst_busy_wait", 64'(seen), 64'(0));
        Busy_clkA = 1'b0;
        tick();
        check("rst_resume", 64'({FlagIn_clkA, gnt_id}), 64'({1'b1, 3'd0}));

        // ---- transfer counter wrap from 0xFFFE ----
        doReset();
        tick();
        force dut.xfer_cnt = 16'hFFFE;
        tick();
        release dut.xfer_cnt;
        check("wrap_preload", 64'(xfer_cnt), 64'(16'hFFFE));
        req = 4'b0001; Busy_clkA = 1'b0;
        repeat (4) tick();
        check("wrap_ffff", 64'(xfer_cnt), 64'(16'hFFFF));
        repeat (4) tick();
        check("wrap_zero", 64'(xfer_cnt), 64'(16'h0000));
        req = '0;

        // ---- random traffic vs reference model ----
        reqHeld = '0;
        for (int c = 0; c < 400; c++) begin
            reqHeld   = reqHeld | N'($urandom & $urandom & $urandom);
            rstA_n    = (c == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
            Busy_clkA = ($urandom_range(0, 9) < 5);
            data_in   = $urandom;
            req       = reqHeld;
            modelStep(rstA_n, req, Busy_clkA, data_in);
            tick();
            check($sformatf("rand%0d", c), actVec(), 64'({mFlag, mGnt, mBus, mId, mXfer, mErr}));
            reqHeld = reqHeld & ~gnt;
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
